lifo_drain_ctrl: RTL and testbench

Downstream consumer of the 8-entry LIFO stack block. It issues pop requests to the stack, captures the popped word, and presents it on a valid/ready output stream. A burst is started by a one-cycle `start` pulse. The burst either drains a programmed number of entries or drains until the stack reports empty. The block never pushes; the upstream producer owns the push side.

---
 rtl/lifo_pkg.sv | 15 +
 rtl/lifo_drain_ctrl.sv | 145 ++++++++++++++
 tb/tb_lifo_drain_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lifo_pkg.sv
// Shared definitions for the LIFO stack and its drain controller.
package lifo_pkg;

  localparam int LIFO_DATA_W = 8;
  localparam int LIFO_DEPTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/lifo_drain_ctrl.sv
// Pops words from the LIFO stack and replays them on a valid/ready stream,
// either for a programmed count or until the stack runs dry.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | decide whether to pop the first word of the burst
// WAIT  | stack is presenting the popped word; capture it
// HOLD  | word offered downstream; may chain the next pop on handshake
// DONE  | one-cycle done pulse, then back to IDLE
module lifo_drain_ctrl
  import lifo_pkg::*;
#(
  parameter int DATA_W = LIFO_DATA_W,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              abort,
  output logic              stk_pop,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_is_empty,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  drained_cnt
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                unlimited_q, unlimited_d;
  logic                m_valid_q, m_valid_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [CNT_W-1:0]    drained_q, drained_d;
  logic                pop_req;
  logic                hs;
  logic                owed;

  assign hs   = m_valid_q & m_ready;
  assign owed = unlimited_q | (remaining_q != '0);

  // Next-state and next-output logic; the pop request is combinational so
  // it can follow the handshake in the same cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unlimited_d = unlimited_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = aborted_q;
    drained_d   = drained_q;
    pop_req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = burst_len;
          unlimited_d = (burst_len == '0);
          drained_d   = '0;
          aborted_d   = 1'b0;
          busy_d      = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (stk_is_empty || !owed || abort) begin
          done_d    = 1'b1;
          aborted_d = abort;
          state_d   = DONE;
        end else begin
          pop_req = 1'b1;
          if (!unlimited_q) remaining_d = remaining_q - 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        m_data_d  = stk_data_out;
        m_valid_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (hs) begin
          if (drained_q != '1) drained_d = drained_q + 1'b1;
          m_valid_d = 1'b0;
          if (!abort && !stk_is_empty && owed) begin
            pop_req = 1'b1;
            if (!unlimited_q) remaining_d = remaining_q - 1'b1;
            state_d = WAIT;
          end else begin
            done_d    = 1'b1;
            aborted_d = abort;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      unlimited_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      drained_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      unlimited_q <= unlimited_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      drained_q   <= drained_d;
    end
  end

  assign stk_pop     = pop_req;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign drained_cnt = drained_q;

endmodule

// File: tb/tb_lifo_drain_ctrl.sv
// Bench for lifo_drain_ctrl with a behavioural 8-entry stack.
module tb_lifo_drain_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, m_ready;
  logic [CW-1:0] burst_len;
  logic          stk_pop, stk_is_empty, m_valid, busy, done, aborted;
  logic [DW-1:0] stk_data_out, m_data;
  logic [CW-1:0] drained_cnt;

  always #5 clk = ~clk;

  lifo_drain_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .abort(abort),
    .stk_pop(stk_pop), .stk_data_out(stk_data_out), .stk_is_empty(stk_is_empty),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
    .done(done), .aborted(aborted), .drained_cnt(drained_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // behavioural stack: registered output one cycle after pop
  logic          s_clr = 1'b0, s_push = 1'b0;
  logic [DW-1:0] s_pdata = '0;
  logic [DW-1:0] smem [8];
  int            scnt = 0;
  always @(posedge clk) begin
    if (s_clr) begin
      scnt <= 0;
    end else if (s_push && scnt < 8) begin
      smem[scnt] <= s_pdata;
      scnt <= scnt + 1;
    end else if (stk_pop && scnt > 0) begin
      stk_data_out <= smem[scnt-1];
      scnt <= scnt - 1;
    end
  end
  assign stk_is_empty = (scnt == 0);

  // reference: contents in push order; a drain takes words from the back
  logic [DW-1:0] model_stk[$];
  logic [DW-1:0] got[$];
  int            pop_cyc[$];
  int            cyc = 0;
  int            start_cyc, done_cyc;
  bit            mon_en = 0;
  logic          prev_pop = 0, prev_v = 0, prev_r = 0;
  logic [DW-1:0] prev_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // protocol monitor and output collector
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (stk_pop) begin
        pop_cyc.push_back(cyc);
        chk("pop_while_empty", {31'd0, stk_is_empty}, 0);
        chk("pop_back_to_back", {31'd0, prev_pop}, 0);
      end
      if (prev_v && !prev_r) begin
        chk("valid_held", {31'd0, m_valid}, 1);
        chk("data_held", {24'd0, m_data}, {24'd0, prev_d});
      end
      if (m_valid && m_ready) got.push_back(m_data);
    end
    prev_pop <= stk_pop;
    prev_v   <= m_valid;
    prev_r   <= m_ready;
    prev_d   <= m_data;
  end

  task automatic load(input logic [DW-1:0] vals[$]);
    @(posedge clk); #1;
    s_clr = 1'b1;
    @(posedge clk); #1;
    s_clr = 1'b0;
    model_stk.delete();
    foreach (vals[i]) begin
      s_push = 1'b1;
      s_pdata = vals[i];
      model_stk.push_back(vals[i]);
      @(posedge clk); #1;
    end
    s_push = 1'b0;
  endtask

  task automatic preload(input int n);
    logic [DW-1:0] q[$];
    for (int i = 0; i < n; i++) q.push_back(DW'($urandom_range(0, 255)));
    load(q);
  endtask

  // called at posedge+1; returns at the negedge where done is seen
  task automatic wait_done(input int rpct, input bit ab, output bit ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      m_ready = ($urandom_range(1, 100) <= rpct);
      if (ab && m_valid) abort = 1'b1;
      @(negedge clk);
      if (done) begin
        ok = 1;
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_seen", {31'd0, ok}, 1);
  endtask

  task automatic kick(input int blen, input int rpct);
    got.delete();
    pop_cyc.delete();
    @(posedge clk); #1;
    start = 1'b1;
    burst_len = CW'(blen);
    m_ready = ($urandom_range(1, 100) <= rpct);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_burst(input int exp_cnt, input int exp_left, input bit exp_ab);
    logic [DW-1:0] e;
    chk("drained_cnt", drained_cnt, exp_cnt);
    chk("aborted", {31'd0, aborted}, {31'd0, exp_ab});
    chk("busy_at_done", {31'd0, busy}, 1);
    chk("words_delivered", got.size(), exp_cnt);
    for (int i = 0; i < exp_cnt; i++) begin
      e = model_stk.pop_back();
      if (i < got.size()) chk("word_order", {24'd0, got[i]}, {24'd0, e});
    end
    chk("stack_left", scnt, exp_left);
    @(posedge clk); #1;
    abort = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("busy_after", {31'd0, busy}, 0);
  endtask

  typedef struct {
    int n; int blen; int rpct; bit ab;
    int cnt; int left; bit abx; int lat; int npop;
  } vec_t;
  vec_t tbl[8];

  initial begin
    bit            ok;
    int            n, blen, cnt;
    logic [DW-1:0] q[$];

    //     n blen rpct ab cnt left abx lat npop  (lat/npop -1 = unchecked)
    tbl[0] = '{3, 0, 100, 0, 3, 0, 0,  8,  3};
    tbl[1] = '{5, 2, 100, 0, 2, 3, 0, -1,  2};
    tbl[2] = '{0, 0, 100, 0, 0, 0, 0,  2,  0};
    tbl[3] = '{4, 0, 100, 1, 1, 3, 1, -1,  1};
    tbl[4] = '{8, 0,  50, 0, 8, 0, 0, -1,  8};
    tbl[5] = '{8, 8,  70, 0, 8, 0, 0, -1,  8};
    tbl[6] = '{3, 5, 100, 0, 3, 0, 0, -1,  3};
    tbl[7] = '{6, 1,  40, 0, 1, 5, 0, -1,  1};

    rst = 1'b1; start = 1'b1; abort = 1'b0; m_ready = 1'b0; burst_len = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_aborted", {31'd0, aborted}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_drained", drained_cnt, 0);
    chk("rst_pop", {31'd0, stk_pop}, 0);
    mon_en = 1;

    // table-driven bursts
    for (int t = 0; t < 8; t++) begin
      if (t == 0) begin
        q = '{8'hA1, 8'hB2, 8'hC3};
        load(q);
      end else begin
        preload(tbl[t].n);
      end
      kick(tbl[t].blen, tbl[t].rpct);
      wait_done(tbl[t].rpct, tbl[t].ab, ok);
      chk("pop_count", pop_cyc.size(), tbl[t].npop);
      if (tbl[t].lat >= 0) chk("done_latency", done_cyc - start_cyc, tbl[t].lat);
      if (t == 0 && pop_cyc.size() == 3) begin
        chk("pop_spacing_1", pop_cyc[1] - pop_cyc[0], 2);
        chk("pop_spacing_2", pop_cyc[2] - pop_cyc[1], 2);
      end
      check_burst(tbl[t].cnt, tbl[t].left, tbl[t].abx);
    end

    // downstream stall: word and valid held, no pop while stalled
    q = '{8'h11, 8'h22};
    load(q);
    kick(0, 0);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = m_valid;
      @(posedge clk); #1;
    end
    chk("stall_valid_seen", {31'd0, ok}, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, m_valid}, 1);
      chk("stall_data", {24'd0, m_data}, 32'h22);
      chk("stall_no_pop", {31'd0, stk_pop}, 0);
      @(posedge clk); #1;
    end
    wait_done(100, 0, ok);
    check_burst(2, 0, 0);

    // reset in WAIT, with a simultaneous start that must be ignored
    preload(4);
    kick(0, 0);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      ok = stk_pop;
      @(posedge clk); #1;
    end
    chk("rst_pop_seen", {31'd0, ok}, 1);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("wrst_busy", {31'd0, busy}, 0);
    chk("wrst_m_valid", {31'd0, m_valid}, 0);
    chk("wrst_pop", {31'd0, stk_pop}, 0);
    chk("wrst_done", {31'd0, done}, 0);
    chk("wrst_m_data", {24'd0, m_data}, 0);
    chk("wrst_drained", drained_cnt, 0);
    @(negedge clk);
    chk("wrst_start_ignored", {31'd0, busy}, 0);
    chk("wrst_stack_left", scnt, 3);

    // randomized bursts against the count/order rule
    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 8);
      blen = $urandom_range(0, 10);
      cnt = (blen == 0) ? n : ((blen < n) ? blen : n);
      preload(n);
      kick(blen, $urandom_range(30, 100));
      wait_done($urandom_range(30, 100), 0, ok);
      check_burst(cnt, n - cnt, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
